dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory behind the pipeline MEM stage. Port 0 is the pipeline (lw/sw traffic); port 1 is a secondary master (program loader / debug). Port 0 has fixed priority, with a starvation guard that forces a port 1 grant. The block drives the memory's write-enable, address and write-data, and returns registered read data with a valid strobe. It raises a stall to the pipeline whenever port 0 is denied.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied cycles of port 1 before a forced grant (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  access request, port 0 / port 1.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  ADDR_W  byte address (word aligned expected).
- wdata0 / wdata1  in  DATA_W  store data.
- gnt0 / gnt1  out  1  access performed this cycle (combinational).
- stall0  out  1  req0 & ~gnt0; freezes the pipeline.
- rvalid0 / rvalid1  out  1  registered load-data valid, one cycle after a granted load.
- rdata0 / rdata1  out  DATA_W  registered load data; holds until the next granted load on that port.
- err0 / err1  out  1  registered one-cycle pulse: granted access was misaligned.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data, combinational from mem_addr.

## Operation
- FSM states: NORMAL, FORCE1.
- NORMAL: gnt0 = req0; gnt1 = req1 & ~req0.
- FORCE1: gnt1 = req1; gnt0 = req0 & ~req1.
- Starvation counter (width clog2(STARVE_LIMIT)+1):
  - Increments when req1 & ~gnt1.
  - Clears when gnt1 or ~req1.
- NORMAL→FORCE1 when port 1 is denied and counter == STARVE_LIMIT-1.
- FORCE1→NORMAL after any cycle in FORCE1: either port 1 was granted once, or req1 dropped.
- Memory mux:
  - Granted port drives mem_addr and mem_wd.
  - No grant: mem_addr/mem_wd = port 0 values, mem_we = 0.
- mem_we = granted port's we & aligned, where aligned = addr[1:0] == 0.
- Misaligned granted store: write suppressed.
- Misaligned granted access (load or store): errN pulses next cycle, rvalidN stays 0, rdataN unchanged.
- Aligned granted load on port N: rdataN <= mem_rd, rvalidN <= 1 at the edge. Otherwise rvalidN <= 0.
- At most one grant per cycle; gnt0 & gnt1 never both 1.
- While rst_n = 0: gnt0, gnt1 and mem_we are forced to 0. stall0 = req0.

## Timing
- Reset values: state NORMAL, counter 0, rvalid0/1 0, rdata0/1 0, err0/1 0.
- Store: memory written at the same edge the grant is asserted; latency 0 extra cycles.
- Load: data and rvalid appear 1 cycle after the grant cycle.
- Back-to-back loads on the same port produce back-to-back rvalid pulses.
- Port 1 worst-case wait with port 0 continuously requesting: STARVE_LIMIT cycles, granted on cycle STARVE_LIMIT+1. Port 0 stalls exactly that one cycle.
- Simultaneous req0 & req1 in FORCE1: port 1 wins and stall0 = 1 for that cycle.
- Reset asserted mid-load: the pending rvalid is cleared. No memory write occurs in the reset cycle.
- Requests must be held until granted. Dropping a request before grant abandons it, with no side effects.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with req0 = req1 = 1 and we = 1 → gnt 0/0, mem_we 0, all registered outputs 0, stall0 = 1.
- Port 0 store then load:
  - Store: req0, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF → gnt0 = 1, mem_we = 1.
  - Next cycle, load addr0 = 0x10 → cycle after: rvalid0 = 1, rdata0 = 0xDEADBEEF.
- Contention with STARVE_LIMIT = 4: req0 and req1 held high (load, addr1 = 0x20) → gnt0 for 4 cycles.
  - Cycle 5: gnt1 = 1, stall0 = 1.
  - Cycle 6: rvalid1 = 1, gnt0 = 1, counter = 0.
- Port 1 alone: req1 store to 0x24 with req0 = 0 → gnt1 the same cycle, no stall0, FSM stays NORMAL.
- Misaligned access: req0 store to 0x13 → gnt0 = 1, mem_we = 0, err0 pulses 1 cycle later. A following load from 0x10 returns the prior value.
- Reset mid-operation: granted load on port 1 followed by rst_n = 0 at the next edge → rvalid1 = 0, counter 0, FSM NORMAL.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory behind the MEM stage.
// Port 0 (pipeline) has fixed priority; a starvation counter forces a port 1 grant.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              stall0,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {NORMAL, FORCE1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]  rdata0_q, rdata0_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d;
  logic               err0_q, err0_d;
  logic               err1_q, err1_d;
  logic               aligned0, aligned1;
  logic               starved1;

  assign aligned0 = (addr0[1:0] == 2'b00);
  assign aligned1 = (addr1[1:0] == 2'b00);

  // Grants are suppressed entirely while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        NORMAL: begin
          gnt0 = req0;
          gnt1 = req1 & ~req0;
        end
        FORCE1: begin
          gnt1 = req1;
          gnt0 = req0 & ~req1;
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign stall0   = req0 & ~gnt0;
  assign starved1 = req1 & ~gnt1;

  always_comb begin
    mem_addr = addr0;
    mem_wd   = wdata0;
    mem_we   = 1'b0;
    if (gnt1) begin
      mem_addr = addr1;
      mem_wd   = wdata1;
      mem_we   = we1 & aligned1;
    end else if (gnt0) begin
      mem_we   = we0 & aligned0;
    end
  end

  // FORCE1 lasts exactly one cycle: port 1 is either served or has withdrawn.
  always_comb begin
    state_d = state_q;
    cnt_d   = starved1 ? cnt_q + CNT_W'(1) : '0;
    case (state_q)
      NORMAL:  if (starved1 && (cnt_q == CNT_W'(STARVE_LIMIT - 1))) state_d = FORCE1;
      FORCE1:  state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    rvalid0_d = gnt0 & ~we0 & aligned0;
    rvalid1_d = gnt1 & ~we1 & aligned1;
    err0_d    = gnt0 & ~aligned0;
    err1_d    = gnt1 & ~aligned1;
    rdata0_d  = rvalid0_d ? mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rd : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule
